// File: rtl/debounce_scheduler.sv
// Debounces N_IN raw inputs against one shared sample tick and queues accepted edges,
// chosen round-robin, into a first-word-fall-through event FIFO drained over valid/ready.
module debounce_scheduler #(
  parameter int unsigned N_IN         = 5,
  parameter int unsigned TICK_CYCLES  = 100_000,
  parameter int unsigned STABLE_TICKS = 20,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         raw_in,
  output logic [N_IN-1:0]         level_out,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_IN)-1:0] evt_idx,
  output logic                    evt_rise,
  output logic                    evt_overflow,
  input  logic                    clr_overflow
);
  localparam int unsigned IdxW  = $clog2(N_IN);
  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned StabW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  logic [N_IN-1:0]  sync1_q, sync2_q;
  logic [TickW-1:0] tcnt_q;
  logic             tick;
  logic [StabW-1:0] scnt_q [N_IN];
  logic [StabW-1:0] scnt_d [N_IN];
  logic [N_IN-1:0]  level_q, level_d, pend_q, pend_d, pedge_q, pedge_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic             ovf_q, ovf_d;

  logic [IdxW:0]    mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop, push_ok;
  logic             grant, grant_edge;
  logic [IdxW-1:0]  grant_idx;

  assign tick = (tcnt_q == TickW'(TICK_CYCLES - 1));

  assign evt_valid    = (count_q != '0);
  assign evt_idx      = evt_valid ? mem_q[rptr_q][IdxW:1] : '0;
  assign evt_rise     = evt_valid ? mem_q[rptr_q][0] : 1'b0;
  assign level_out    = level_q;
  assign evt_overflow = ovf_q;

  assign pop     = evt_valid & evt_ready;
  assign push_ok = (count_q < CntW'(FIFO_DEPTH)) | pop;

  // Round-robin: first pending input at or after rr, wrapping.
  always_comb begin
    int j;
    logic [IdxW-1:0] cand;
    grant      = 1'b0;
    grant_idx  = '0;
    grant_edge = 1'b0;
    j          = 0;
    cand       = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      j = int'(rr_q) + k;
      if (j >= int'(N_IN)) j = j - int'(N_IN);
      cand = IdxW'(j);
      if (push_ok && !grant && pend_q[cand]) begin
        grant      = 1'b1;
        grant_idx  = cand;
        grant_edge = pedge_q[cand];
      end
    end
    rr_d = rr_q;
    if (grant) rr_d = (grant_idx == IdxW'(N_IN - 1)) ? '0 : grant_idx + IdxW'(1);
  end

  always_comb begin
    level_d = level_q;
    pend_d  = pend_q;
    pedge_d = pedge_q;
    scnt_d  = scnt_q;
    ovf_d   = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (grant && grant_idx == IdxW'(i)) pend_d[i] = 1'b0;
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          scnt_d[i] = '0;
        end else if (scnt_q[i] == StabW'(STABLE_TICKS - 1)) begin
          level_d[i] = sync2_q[i];
          scnt_d[i]  = '0;
          pend_d[i]  = 1'b1;
          pedge_d[i] = sync2_q[i];
          // A grant this cycle carries the old edge out, so nothing is lost.
          if (pend_q[i] && !(grant && grant_idx == IdxW'(i))) ovf_d = 1'b1;
        end else begin
          scnt_d[i] = scnt_q[i] + StabW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      tcnt_q  <= '0;
      level_q <= '0;
      pend_q  <= '0;
      pedge_q <= '0;
      rr_q    <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(N_IN); i++) scnt_q[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      tcnt_q  <= tick ? '0 : tcnt_q + TickW'(1);
      level_q <= level_d;
      pend_q  <= pend_d;
      pedge_q <= pedge_d;
      scnt_q  <= scnt_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      if (grant) begin
        mem_q[wptr_q] <= {grant_idx, grant_edge};
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      case ({grant, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
